// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states, frame constants,
// and the per-state decode of the registered control outputs.
package imem_loader_pkg;
  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR
  } state_e;

  typedef struct packed {
    logic rx_ready;
    logic im_we;
    logic cpu_hold;
    logic done;
    logic error;
  } ctl_t;

  function automatic ctl_t state_ctl(input state_e s);
    ctl_t c;
    c.rx_ready = (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    c.im_we    = (s == WRITE);
    c.cpu_hold = (s != DONE);
    c.done     = (s == DONE);
    c.error    = (s == ERROR);
    return c;
  endfunction
endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler: each byte shifts in at the top, so after
// four bytes the first one sits in [7:0]. word_ready flags the accept of the last byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_byte_en,
  input  logic [7:0]                  i_byte,
  output logic [8*BYTES_PER_WORD-1:0] o_word,
  output logic                        o_word_ready
);
  logic [1:0]                  r_lane;
  logic [8*BYTES_PER_WORD-1:0] r_word;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_byte_en) begin
      r_lane <= r_lane + 2'd1;
      r_word <= {i_byte, r_word[8*BYTES_PER_WORD-1:8]};
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_byte_en && (r_lane == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader for the instruction memory; holds the core until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_im_we,
  output logic [31:0] o_im_addr,
  output logic [31:0] o_im_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);
  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e FINISH = CHECK;
`else
  localparam state_e FINISH = DONE;
`endif

  state_e           r_state, w_state_nxt;
  ctl_t             r_ctl;
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_accept, w_pack_en, w_word_ready, w_rearm, w_last_word;
  logic [LEN_W-1:0] w_len_hdr;
  logic [LEN_W:0]   w_idx_nxt;

  assign w_accept    = i_rx_valid && r_ctl.rx_ready;
  assign w_pack_en   = w_accept && (r_state == DATA);
  assign w_rearm     = i_start && ((r_state == DONE) || (r_state == ERROR));
  assign w_len_hdr   = {i_rx_data, r_len[7:0]};
  assign w_idx_nxt   = (LEN_W+1)'(r_idx) + (LEN_W+1)'(1);
  assign w_last_word = (w_idx_nxt == {1'b0, r_len});

  byte_word_packer u_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_rearm),
    .i_byte_en   (w_pack_en),
    .i_byte      (i_rx_data),
    .o_word      (o_im_wdata),
    .o_word_ready(w_word_ready)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LEN_LO: if (w_accept) w_state_nxt = LEN_HI;
      LEN_HI: if (w_accept) begin
        if (w_len_hdr == '0)                                        w_state_nxt = FINISH;
        else if ((LEN_W+1)'(w_len_hdr) > (LEN_W+1)'(DEPTH_WORDS))   w_state_nxt = ERROR;
        else                                                        w_state_nxt = DATA;
      end
      DATA:   if (w_word_ready) w_state_nxt = WRITE;
      WRITE:  w_state_nxt = w_last_word ? FINISH : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:  if (w_accept) w_state_nxt = (i_rx_data == r_csum) ? DONE : ERROR;
`endif
      DONE, ERROR: if (i_start) w_state_nxt = LEN_LO;
      default: w_state_nxt = r_state;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= LEN_LO;
      r_ctl   <= state_ctl(LEN_LO);
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ctl   <= state_ctl(w_state_nxt);
      if (r_state == LEN_LO && w_accept) r_len[7:0] <= i_rx_data;
      if (r_state == LEN_HI && w_accept) r_len      <= w_len_hdr;
      if (r_state == WRITE) begin
        r_idx  <= r_idx + 1'b1;
        r_addr <= r_addr + 32'd4;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_pack_en) r_csum <= r_csum + i_rx_data;
`endif
      if (w_rearm) begin
        r_len  <= '0;
        r_idx  <= '0;
        r_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum <= '0;
`endif
      end
    end
  end

  assign o_rx_ready = r_ctl.rx_ready;
  assign o_im_we    = r_ctl.im_we;
  assign o_im_addr  = r_addr;
  assign o_cpu_hold = r_ctl.cpu_hold;
  assign o_done     = r_ctl.done;
  assign o_error    = r_ctl.error;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; follows IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_boot_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, im_we, cpu_hold, done, error;
  logic [31:0] im_addr, im_wdata;

  int checks = 0;
  int errors = 0;
  int wr_n = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  imem_boot_loader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_im_we(im_we), .o_im_addr(im_addr), .o_im_wdata(im_wdata),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  // Write-port log, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we && wr_n < 64) begin
      wr_addr[wr_n] = im_addr;
      wr_data[wr_n] = im_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_byte_timeout byte %h rx_ready stuck at %b, need 1", b, rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 7;
    if (rx_ready !== 1'b1)     begin errors++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
    if (im_we !== 1'b0)        begin errors++; $display("FAIL reset_im_we got %b exp 0", im_we); end
    if (im_addr !== 32'h0)     begin errors++; $display("FAIL reset_im_addr got %h exp 0", im_addr); end
    if (im_wdata !== 32'h0)    begin errors++; $display("FAIL reset_im_wdata got %h exp 0", im_wdata); end
    if (cpu_hold !== 1'b1)     begin errors++; $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); end
    if (done !== 1'b0)         begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (error !== 1'b0)        begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int w0;
    w0 = wr_n;
    send_hdr(16'd2);
    send_word(32'h00000513, 1'b0);
    @(negedge clk);
    checks += 4;
    if (im_we !== 1'b1)            begin errors++; $display("FAIL basic_we0 got %b exp 1", im_we); end
    if (im_addr !== 32'h0)         begin errors++; $display("FAIL basic_addr0 got %h exp 0", im_addr); end
    if (im_wdata !== 32'h00000513) begin errors++; $display("FAIL basic_data0 got %h exp 00000513", im_wdata); end
    if (cpu_hold !== 1'b1)         begin errors++; $display("FAIL basic_hold_mid got %b exp 1", cpu_hold); end
    send_word(32'h00100593, 1'b0);
    @(negedge clk);
    checks += 3;
    if (im_we !== 1'b1)            begin errors++; $display("FAIL basic_we1 got %b exp 1", im_we); end
    if (im_addr !== 32'h4)         begin errors++; $display("FAIL basic_addr1 got %h exp 4", im_addr); end
    if (im_wdata !== 32'h00100593) begin errors++; $display("FAIL basic_data1 got %h exp 00100593", im_wdata); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0)     begin errors++; $display("FAIL basic_check_done got %b exp 0", done); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL basic_check_ready got %b exp 1", rx_ready); end
    send_byte(8'hC0);
`endif
    @(negedge clk);
    checks += 5;
    if (done !== 1'b1)      begin errors++; $display("FAIL basic_done got %b exp 1", done); end
    if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL basic_hold got %b exp 0", cpu_hold); end
    if (rx_ready !== 1'b0)  begin errors++; $display("FAIL basic_ready_done got %b exp 0", rx_ready); end
    if (error !== 1'b0)     begin errors++; $display("FAIL basic_error got %b exp 0", error); end
    if (wr_n - w0 !== 2)    begin errors++; $display("FAIL basic_wr_count got %0d exp 2", wr_n - w0); end
  endtask

  task automatic test_gaps();
    int w0;
    rearm();
    checks += 2;
    if (done !== 1'b0)     begin errors++; $display("FAIL rearm_done got %b exp 0", done); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rearm_hold got %b exp 1", cpu_hold); end
    w0 = wr_n;
    send_hdr(16'd2);
    send_word(32'hDEADBEEF, 1'b1);
    send_word(32'h01234567, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    @(negedge clk);
    checks += 6;
    if (wr_n - w0 !== 2)               begin errors++; $display("FAIL gaps_wr_count got %0d exp 2", wr_n - w0); end
    if (wr_addr[w0] !== 32'h0)         begin errors++; $display("FAIL gaps_addr0 got %h exp 0", wr_addr[w0]); end
    if (wr_data[w0] !== 32'hDEADBEEF)  begin errors++; $display("FAIL gaps_data0 got %h exp deadbeef", wr_data[w0]); end
    if (wr_addr[w0+1] !== 32'h4)       begin errors++; $display("FAIL gaps_addr1 got %h exp 4", wr_addr[w0+1]); end
    if (wr_data[w0+1] !== 32'h01234567) begin errors++; $display("FAIL gaps_data1 got %h exp 01234567", wr_data[w0+1]); end
    if (done !== 1'b1)                 begin errors++; $display("FAIL gaps_done got %b exp 1", done); end
    // Bytes offered while not ready must be ignored
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks += 2;
    if (done !== 1'b1)   begin errors++; $display("FAIL noready_done got %b exp 1", done); end
    if (wr_n - w0 !== 2) begin errors++; $display("FAIL noready_wr_count got %0d exp 2", wr_n - w0); end
  endtask

  task automatic test_overflow();
    int w0;
    rearm();
    w0 = wr_n;
    send_hdr(16'd1025);
    @(negedge clk);
    checks += 5;
    if (error !== 1'b1)    begin errors++; $display("FAIL ovf_error got %b exp 1", error); end
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", rx_ready); end
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b exp 1", cpu_hold); end
    if (done !== 1'b0)     begin errors++; $display("FAIL ovf_done got %b exp 0", done); end
    if (wr_n !== w0)       begin errors++; $display("FAIL ovf_wr_count got %0d exp 0", wr_n - w0); end
    rearm();
    checks += 2;
    if (error !== 1'b0)    begin errors++; $display("FAIL ovf_rearm_error got %b exp 0", error); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL ovf_rearm_ready got %b exp 1", rx_ready); end
  endtask

  task automatic test_zero();
    int w0;
    w0 = wr_n;
    send_hdr(16'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0)     begin errors++; $display("FAIL zero_check_done got %b exp 0", done); end
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL zero_check_ready got %b exp 1", rx_ready); end
    send_byte(8'h00);
`endif
    @(negedge clk);
    checks += 3;
    if (done !== 1'b1)     begin errors++; $display("FAIL zero_done got %b exp 1", done); end
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_hold got %b exp 0", cpu_hold); end
    if (wr_n !== w0)       begin errors++; $display("FAIL zero_wr_count got %0d exp 0", wr_n - w0); end
    rearm();
  endtask

  task automatic test_reset_mid();
    send_hdr(16'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 5;
    if (rx_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready got %b exp 1", rx_ready); end
    if (im_we !== 1'b0)     begin errors++; $display("FAIL midrst_we got %b exp 0", im_we); end
    if (im_addr !== 32'h0)  begin errors++; $display("FAIL midrst_addr got %h exp 0", im_addr); end
    if (im_wdata !== 32'h0) begin errors++; $display("FAIL midrst_wdata got %h exp 0", im_wdata); end
    if (cpu_hold !== 1'b1)  begin errors++; $display("FAIL midrst_hold got %b exp 1", cpu_hold); end
    reset = 1'b0;
    send_hdr(16'd1);
    send_word(32'hCAFEF00D, 1'b0);
    @(negedge clk);
    checks += 3;
    if (im_we !== 1'b1)            begin errors++; $display("FAIL midrst_we1 got %b exp 1", im_we); end
    if (im_addr !== 32'h0)         begin errors++; $display("FAIL midrst_addr1 got %h exp 0", im_addr); end
    if (im_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_data1 got %h exp cafef00d", im_wdata); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hC5);
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got %b exp 1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    int w0;
    rearm();
    w0 = wr_n;
    send_hdr(16'd1);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h00);
    @(negedge clk);
    checks += 5;
    if (error !== 1'b1)               begin errors++; $display("FAIL badcs_error got %b exp 1", error); end
    if (done !== 1'b0)                begin errors++; $display("FAIL badcs_done got %b exp 0", done); end
    if (cpu_hold !== 1'b1)            begin errors++; $display("FAIL badcs_hold got %b exp 1", cpu_hold); end
    if (wr_n - w0 !== 1)              begin errors++; $display("FAIL badcs_wr_count got %0d exp 1", wr_n - w0); end
    if (wr_data[w0] !== 32'h11223344) begin errors++; $display("FAIL badcs_data got %h exp 11223344", wr_data[w0]); end
  endtask
`else
  task automatic test_no_trailer();
    // After DONE the loader must not take a trailing byte
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL trailer_ready got %b exp 0", rx_ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_zero();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_csum();
`else
    test_no_trailer();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
